// File: rtl/local_store_responder.sv
// Quadword local store with a fixed-latency pipeline port and a tagged DMA port.
// The pipeline port always wins the single array access available each cycle.
module local_store_responder #(
  parameter int DEPTH   = 2048,
  parameter int ADDR_W  = 18,
  parameter int LATENCY = 6,
  parameter int TAG_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pipe_mem_read,
  input  logic              pipe_mem_write,
  input  logic [ADDR_W-1:0] pipe_addr,
  input  logic [127:0]      pipe_wdata,
  output logic [127:0]      pipe_rdata,
  output logic              pipe_rdata_valid,
  output logic              pipe_addr_err,
  input  logic              dma_req_valid,
  output logic              dma_req_ready,
  input  logic              dma_req_write,
  input  logic [ADDR_W-1:0] dma_req_addr,
  input  logic [127:0]      dma_req_wdata,
  input  logic [TAG_W-1:0]  dma_req_tag,
  output logic              dma_rsp_valid,
  output logic              dma_rsp_write,
  output logic [127:0]      dma_rsp_data,
  output logic [TAG_W-1:0]  dma_rsp_tag,
  output logic              dma_rsp_err
);

  localparam int QW = ADDR_W - 4;
  localparam int AW = $clog2(DEPTH);
  localparam logic [QW-1:0] DEPTH_Q = QW'(DEPTH);

  logic [127:0] mem [DEPTH];

  logic          pipeAct;
  logic          dmaAcc;
  logic [QW-1:0] pQw;
  logic [QW-1:0] dQw;
  logic          pOk;
  logic          dOk;
  logic [127:0]  pRd;
  logic [127:0]  dRd;
  logic          unusedLow;

  logic             pV [LATENCY];
  logic             pE [LATENCY];
  logic [127:0]     pD [LATENCY];
  logic             dV [LATENCY];
  logic             dW [LATENCY];
  logic             dE [LATENCY];
  logic [TAG_W-1:0] dT [LATENCY];
  logic [127:0]     dD [LATENCY];

  assign pipeAct       = pipe_mem_read | pipe_mem_write;
  assign dma_req_ready = dma_req_valid & ~pipeAct;
  assign dmaAcc        = dma_req_ready;

  assign pQw = pipe_addr[ADDR_W-1:4];
  assign dQw = dma_req_addr[ADDR_W-1:4];
  assign pOk = pQw < DEPTH_Q;
  assign dOk = dQw < DEPTH_Q;

  assign unusedLow = ^{pipe_addr[3:0], dma_req_addr[3:0]};

  // Array read at accept; a same-cycle pipe store forwards its data.
  always_comb begin
    pRd = '0;
    dRd = '0;
    if (pOk) begin
      pRd = pipe_mem_write ? pipe_wdata
                           : mem[pQw[AW-1:0]];
    end
    if (dOk && !dma_req_write) begin
      dRd = mem[dQw[AW-1:0]];
    end
  end

  // Commit writes at the accepting edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (pipe_mem_write && pOk) begin
      mem[pQw[AW-1:0]] <= pipe_wdata;
    end else if (dmaAcc && dma_req_write && dOk) begin
      mem[dQw[AW-1:0]] <= dma_req_wdata;
    end
  end

  // Pipeline response delay line; only loads occupy a slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        pV[i] <= 1'b0;
        pE[i] <= 1'b0;
        pD[i] <= '0;
      end
    end else begin
      pV[0] <= pipe_mem_read;
      pE[0] <= pipe_mem_read & ~pOk;
      pD[0] <= pipe_mem_read ? pRd : '0;
      for (int i = 1; i < LATENCY; i++) begin
        pV[i] <= pV[i-1];
        pE[i] <= pE[i-1];
        pD[i] <= pD[i-1];
      end
    end
  end

  // DMA response delay line; reads and write acks both answer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        dV[i] <= 1'b0;
        dW[i] <= 1'b0;
        dE[i] <= 1'b0;
        dT[i] <= '0;
        dD[i] <= '0;
      end
    end else begin
      dV[0] <= dmaAcc;
      dW[0] <= dmaAcc & dma_req_write;
      dE[0] <= dmaAcc & ~dOk;
      dT[0] <= dmaAcc ? dma_req_tag : '0;
      dD[0] <= dmaAcc ? dRd : '0;
      for (int i = 1; i < LATENCY; i++) begin
        dV[i] <= dV[i-1];
        dW[i] <= dW[i-1];
        dE[i] <= dE[i-1];
        dT[i] <= dT[i-1];
        dD[i] <= dD[i-1];
      end
    end
  end

  assign pipe_rdata_valid = pV[LATENCY-1];
  assign pipe_addr_err    = pE[LATENCY-1];
  assign pipe_rdata       = pD[LATENCY-1];
  assign dma_rsp_valid    = dV[LATENCY-1];
  assign dma_rsp_write    = dW[LATENCY-1];
  assign dma_rsp_err      = dE[LATENCY-1];
  assign dma_rsp_tag      = dT[LATENCY-1];
  assign dma_rsp_data     = dD[LATENCY-1];

endmodule
